// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller:
// direction and FSM encodings, grid geometry, fruit growth table.
package snake_pkg;

  localparam int COORD_WIDTH  = 10;
  localparam int LENGTH_WIDTH = 6;
  localparam int GRID_W       = 64;
  localparam int GRID_H       = 48;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_MOVE      = 3'd2,
    ST_CHECK     = 3'd3,
    ST_RESPAWN   = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_e;

  // Length added per fruit type; type 3 grants a life instead.
  function automatic logic [1:0] fruit_growth(input logic [1:0] t);
    logic [1:0] g;
    case (t)
      2'd0:    g = 2'd1;
      2'd1:    g = 2'd2;
      2'd2:    g = 2'd3;
      default: g = 2'd0;
    endcase
    return g;
  endfunction

  function automatic logic fruit_life(input logic [1:0] t);
    return t == 2'd3;
  endfunction

  // Pairs share bit 1 and differ in bit 0.
  function automatic logic is_opposite(input dir_e a,
                                       input dir_e b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Move pacing divider: counts enabled cycles and flags the
// terminal count; holds while disabled, clears on request.
module move_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game controller: head position, direction, length,
// lives, move pacing, respawn and game-over sequencing.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int START_X        = 10,
  parameter int START_Y        = 10,
  parameter int INIT_LEN       = 3,
  parameter int INIT_LIVES     = 3,
  parameter int MAX_LIVES      = 7,
  parameter int MAX_LENGTH     = 63,
  parameter int TICK_DIV       = 4,
  parameter int RESPAWN_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    collide_in,
  input  logic                    eat_in,
  input  logic [1:0]              fruit_type_in,
  output logic [COORD_WIDTH-1:0]  head_x,
  output logic [COORD_WIDTH-1:0]  head_y,
  output logic [1:0]              dir,
  output logic [LENGTH_WIDTH-1:0] snake_length,
  output logic [2:0]              lives,
  output logic                    step,
  output logic                    game_over,
  output logic [2:0]              state_o
);

  localparam int RW = (RESPAWN_CYCLES > 1) ?
                      $clog2(RESPAWN_CYCLES) : 1;
  localparam int LW = LENGTH_WIDTH + 1;

  state_e                  state_q;
  dir_e                    dir_q;
  dir_e                    pend_q;
  dir_e                    pend_d;
  dir_e                    req_d;
  logic                    req_vld;
  logic [COORD_WIDTH-1:0]  hx_q;
  logic [COORD_WIDTH-1:0]  hy_q;
  logic [COORD_WIDTH-1:0]  hx_d;
  logic [COORD_WIDTH-1:0]  hy_d;
  logic                    bnd_q;
  logic                    bnd_d;
  logic [LENGTH_WIDTH-1:0] len_q;
  logic [LENGTH_WIDTH-1:0] len_d;
  logic [LW-1:0]           len_sum;
  logic [2:0]              lives_q;
  logic [2:0]              lives_up;
  logic                    step_q;
  logic                    go_q;
  logic [RW-1:0]           rsp_q;
  logic                    hit;
  logic                    tick_en;
  logic                    tick_clr;
  logic                    tick_tc;

  assign tick_en  = (state_q == ST_RUN) && !pause;
  assign tick_clr = (state_q != ST_RUN) &&
                    (state_q != ST_PAUSE);

  move_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tc_o  (tick_tc)
  );

  // Highest-priority held button, dropped if it reverses dir.
  always_comb begin
    req_vld = 1'b1;
    req_d   = DIR_RIGHT;
    if (btn_up) begin
      req_d = DIR_UP;
    end else if (btn_down) begin
      req_d = DIR_DOWN;
    end else if (btn_left) begin
      req_d = DIR_LEFT;
    end else if (btn_right) begin
      req_d = DIR_RIGHT;
    end else begin
      req_vld = 1'b0;
    end
    pend_d = pend_q;
    if (req_vld && !is_opposite(req_d, dir_q)) begin
      pend_d = req_d;
    end
  end

  always_comb begin
    hx_d  = hx_q;
    hy_d  = hy_q;
    bnd_d = 1'b0;
    case (dir_q)
      DIR_RIGHT: begin
        if (hx_q == COORD_WIDTH'(GRID_W - 1)) bnd_d = 1'b1;
        else hx_d = hx_q + 1'b1;
      end
      DIR_LEFT: begin
        if (hx_q == '0) bnd_d = 1'b1;
        else hx_d = hx_q - 1'b1;
      end
      DIR_UP: begin
        if (hy_q == '0) bnd_d = 1'b1;
        else hy_d = hy_q - 1'b1;
      end
      default: begin
        if (hy_q == COORD_WIDTH'(GRID_H - 1)) bnd_d = 1'b1;
        else hy_d = hy_q + 1'b1;
      end
    endcase
  end

  always_comb begin
    len_sum = {1'b0, len_q} +
              {{(LW-2){1'b0}}, fruit_growth(fruit_type_in)};
    len_d   = (len_sum > LW'(MAX_LENGTH)) ?
              LENGTH_WIDTH'(MAX_LENGTH) :
              len_sum[LENGTH_WIDTH-1:0];
    lives_up = (lives_q >= 3'(MAX_LIVES)) ?
               3'(MAX_LIVES) : lives_q + 3'd1;
  end

  assign hit = bnd_q || collide_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hx_q    <= COORD_WIDTH'(START_X);
      hy_q    <= COORD_WIDTH'(START_Y);
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      len_q   <= LENGTH_WIDTH'(INIT_LEN);
      lives_q <= 3'(INIT_LIVES);
      step_q  <= 1'b0;
      go_q    <= 1'b0;
      bnd_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          pend_q <= pend_d;
          if (pause) begin
            state_q <= ST_PAUSE;
          end else if (tick_tc) begin
            state_q <= ST_MOVE;
            dir_q   <= pend_d;
            step_q  <= 1'b1;
          end
        end
        ST_MOVE: begin
          hx_q    <= hx_d;
          hy_q    <= hy_d;
          bnd_q   <= bnd_d;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          bnd_q <= 1'b0;
          if (hit) begin
            lives_q <= lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_q <= ST_GAME_OVER;
              go_q    <= 1'b1;
            end else begin
              state_q <= ST_RESPAWN;
              rsp_q   <= '0;
              hx_q    <= COORD_WIDTH'(START_X);
              hy_q    <= COORD_WIDTH'(START_Y);
              dir_q   <= DIR_RIGHT;
              pend_q  <= DIR_RIGHT;
              len_q   <= LENGTH_WIDTH'(INIT_LEN);
            end
          end else begin
            state_q <= ST_RUN;
            if (eat_in) begin
              len_q <= len_d;
              if (fruit_life(fruit_type_in)) lives_q <= lives_up;
            end
          end
        end
        ST_RESPAWN: begin
          if (rsp_q == RW'(RESPAWN_CYCLES - 1)) begin
            state_q <= ST_RUN;
          end else begin
            rsp_q <= rsp_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (pause) state_q <= ST_RUN;
        end
        ST_GAME_OVER: begin
          if (start) begin
            state_q <= ST_RUN;
            go_q    <= 1'b0;
            hx_q    <= COORD_WIDTH'(START_X);
            hy_q    <= COORD_WIDTH'(START_Y);
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            len_q   <= LENGTH_WIDTH'(INIT_LEN);
            lives_q <= 3'(INIT_LIVES);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign head_x       = hx_q;
  assign head_y       = hy_q;
  assign dir          = dir_q;
  assign snake_length = len_q;
  assign lives        = lives_q;
  assign step         = step_q;
  assign game_over    = go_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed and random stimulus for snake_game_sequencer,
// checked each cycle against a game-rules reference model.
module tb_snake_game_sequencer;
  import snake_pkg::*;

  localparam int SX = 10;
  localparam int SY = 10;
  localparam int ILEN = 3;
  localparam int ILIV = 3;
  localparam int MLIV = 7;
  localparam int MLEN = 63;
  localparam int TDIV = 4;
  localparam int RSPC = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic collide_in = 1'b0;
  logic eat_in = 1'b0;
  logic [1:0] fruit_type_in = 2'd0;
  logic [COORD_WIDTH-1:0] head_x;
  logic [COORD_WIDTH-1:0] head_y;
  logic [1:0] dir;
  logic [LENGTH_WIDTH-1:0] snake_length;
  logic [2:0] lives;
  logic step;
  logic game_over;
  logic [2:0] state_o;

  snake_game_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .collide_in    (collide_in),
    .eat_in        (eat_in),
    .fruit_type_in (fruit_type_in),
    .head_x        (head_x),
    .head_y        (head_y),
    .dir           (dir),
    .snake_length  (snake_length),
    .lives         (lives),
    .step          (step),
    .game_over     (game_over),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int steps_seen = 0;

  // Reference model of the game, one update per clock.
  state_e m_st;
  int m_cnt, m_rcnt, m_x, m_y, m_dir, m_pend;
  int m_len, m_lives, m_step, m_go, m_bnd;
  int dx [4] = '{1, -1, 0, 0};
  int dy [4] = '{0, 0, -1, 1};
  int grow [4] = '{1, 2, 3, 0};

  function automatic int requested();
    if (btn_up) return 2;
    if (btn_down) return 3;
    if (btn_left) return 1;
    if (btn_right) return 0;
    return -1;
  endfunction

  function automatic bit reverses(int a, int b);
    return (a / 2 == b / 2) && (a != b);
  endfunction

  task automatic new_life();
    m_x = SX;
    m_y = SY;
    m_dir = 0;
    m_pend = 0;
    m_len = ILEN;
  endtask

  task automatic model_clock();
    int r, nx, ny;
    m_step = 0;
    if (!reset) begin
      m_st = ST_IDLE;
      new_life();
      m_lives = ILIV;
      m_go = 0;
      m_cnt = 0;
      m_rcnt = 0;
      m_bnd = 0;
      return;
    end
    case (m_st)
      ST_IDLE: if (start) begin m_st = ST_RUN; m_cnt = 0; end
      ST_RUN: begin
        r = requested();
        if (r >= 0 && !reverses(r, m_dir)) m_pend = r;
        if (pause) m_st = ST_PAUSE;
        else if (m_cnt == TDIV - 1) begin
          m_cnt = 0;
          m_dir = m_pend;
          m_step = 1;
          m_st = ST_MOVE;
        end else m_cnt++;
      end
      ST_MOVE: begin
        nx = m_x + dx[m_dir];
        ny = m_y + dy[m_dir];
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H)
          m_bnd = 1;
        else begin
          m_x = nx;
          m_y = ny;
        end
        m_st = ST_CHECK;
      end
      ST_CHECK: begin
        if (m_bnd == 1 || collide_in) begin
          m_lives--;
          if (m_lives == 0) begin
            m_st = ST_GAME_OVER;
            m_go = 1;
          end else begin
            new_life();
            m_rcnt = 0;
            m_st = ST_RESPAWN;
          end
        end else begin
          if (eat_in) begin
            m_len = m_len + grow[fruit_type_in];
            if (m_len > MLEN) m_len = MLEN;
            if (fruit_type_in == 2'd3 && m_lives < MLIV) m_lives++;
          end
          m_st = ST_RUN;
        end
        m_bnd = 0;
      end
      ST_RESPAWN: begin
        if (m_rcnt == RSPC - 1) begin
          m_st = ST_RUN;
          m_cnt = 0;
        end else m_rcnt++;
      end
      ST_PAUSE: if (pause) m_st = ST_RUN;
      ST_GAME_OVER: begin
        if (start) begin
          new_life();
          m_lives = ILIV;
          m_go = 0;
          m_cnt = 0;
          m_st = ST_RUN;
        end
      end
      default: m_st = ST_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input int exp);
    n_vec++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("head_x", 32'(head_x), m_x);
    chk("head_y", 32'(head_y), m_y);
    chk("dir", 32'(dir), m_dir);
    chk("length", 32'(snake_length), m_len);
    chk("lives", 32'(lives), m_lives);
    chk("step", 32'(step), m_step);
    chk("game_over", 32'(game_over), m_go);
    chk("state", 32'(state_o), int'(m_st));
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
    if (step === 1'b1) steps_seen++;
    check_all();
  endtask

  task automatic clear_in();
    start = 0; pause = 0; collide_in = 0; eat_in = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic tick(input int n);
    clear_in();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until(input state_e s, input int max);
    int k;
    k = 0;
    clear_in();
    while (m_st != s && k < max) begin
      cyc();
      k++;
    end
    n_vec++;
    assert (m_st == s) else begin
      n_err++;
      $error("FAIL wait_%0d: observed state %0d expected %0d",
             int'(s), state_o, int'(s));
    end
  endtask

  initial begin
    reset = 0;
    cyc();
    cyc();
    chk("rst_x", 32'(head_x), SX);
    chk("rst_state", 32'(state_o), int'(ST_IDLE));
    reset = 1;
    start = 1;
    cyc();
    steps_seen = 0;
    tick(18);
    chk("steps3", 32'(steps_seen), 3);
    chk("x13", 32'(head_x), 13);
    chk("y10", 32'(head_y), 10);

    btn_left = 1; cyc(); btn_left = 0;
    btn_up = 1; cyc(); btn_up = 0;
    tick(4);
    chk("turn_x", 32'(head_x), 13);
    chk("turn_y", 32'(head_y), 9);
    chk("turn_dir", 32'(dir), 2);

    btn_right = 1; cyc();
    tick(5);
    chk("right_x", 32'(head_x), 14);
    chk("right_dir", 32'(dir), 0);
    btn_up = 1; btn_right = 1; cyc();
    tick(5);
    chk("prio_y", 32'(head_y), 8);
    chk("prio_dir", 32'(dir), 2);

    // Walk right into the wall.
    btn_right = 1; cyc();
    clear_in();
    for (int k = 0; k < 600 && m_st != ST_RESPAWN; k++) begin
      cyc();
      if (m_st == ST_CHECK && m_bnd == 1)
        chk("wall_x", 32'(head_x), 63);
    end
    chk("wall_lives", 32'(lives), 2);
    chk("wall_state", 32'(state_o), int'(ST_RESPAWN));
    tick(8);
    chk("rsp_state", 32'(state_o), int'(ST_RUN));
    chk("rsp_x", 32'(head_x), SX);
    chk("rsp_len", 32'(snake_length), ILEN);

    run_until(ST_CHECK, 20);
    eat_in = 1; fruit_type_in = 2'd1; cyc();
    chk("eat_len", 32'(snake_length), 5);
    for (int i = 0; i < 6; i++) begin
      run_until(ST_CHECK, 20);
      eat_in = 1; fruit_type_in = 2'd3; cyc();
    end
    chk("life_sat", 32'(lives), MLIV);
    chk("life_len", 32'(snake_length), 5);
    run_until(ST_CHECK, 20);
    eat_in = 1; collide_in = 1; fruit_type_in = 2'd0; cyc();
    chk("both_lives", 32'(lives), 6);
    chk("both_len", 32'(snake_length), ILEN);

    for (int i = 0; i < 6; i++) begin
      run_until(ST_CHECK, 40);
      collide_in = 1; cyc();
    end
    tick(4);
    chk("go_flag", 32'(game_over), 1);
    chk("go_lives", 32'(lives), 0);
    start = 1; cyc();
    chk("new_lives", 32'(lives), ILIV);
    chk("new_go", 32'(game_over), 0);
    chk("new_state", 32'(state_o), int'(ST_RUN));

    tick(2);
    pause = 1; cyc();
    tick(5);
    chk("paused", 32'(state_o), int'(ST_PAUSE));
    pause = 1; cyc();
    tick(2);
    chk("resume_step", 32'(step), 1);

    run_until(ST_MOVE, 20);
    reset = 0; cyc(); reset = 1;
    chk("mid_rst", 32'(state_o), int'(ST_IDLE));

    start = 1; cyc();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 49) == 0);
      pause = ($urandom_range(0, 59) == 0);
      btn_up = ($urandom_range(0, 7) == 0);
      btn_down = ($urandom_range(0, 7) == 0);
      btn_left = ($urandom_range(0, 7) == 0);
      btn_right = ($urandom_range(0, 7) == 0);
      collide_in = ($urandom_range(0, 7) == 0);
      eat_in = ($urandom_range(0, 1) == 0);
      fruit_type_in = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) != 0);
      cyc();
    end
    reset = 1;
    clear_in();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snake_game_sequencer.md
Name: snake_game_sequencer

Overview:
Top-level game controller for the snake datapath. It owns head position, direction, snake length and lives, and paces movement with a tick divider. Each move it issues a body-shift strobe, then samples the collision and fruit results from the detection/fruit blocks the following cycle. It also sequences respawn after a life loss and game-over; the scoreboard consumes its `game_over` output.

Parameters:
COORD_WIDTH, 10, width of head coordinates (grid units)
LENGTH_WIDTH, 6, width of snake_length
GRID_W, 64, grid columns; legal x is 0..GRID_W-1
GRID_H, 48, grid rows; legal y is 0..GRID_H-1
START_X, 10, respawn/reset head x
START_Y, 10, respawn/reset head y
INIT_LEN, 3, length after reset/respawn
INIT_LIVES, 3, lives after reset/new game
MAX_LIVES, 7, lives saturation
MAX_LENGTH, 63, length saturation
TICK_DIV, 4, clk cycles spent in RUN per move
RESPAWN_CYCLES, 8, pause length after a life loss

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
start  in  1  pulse; begins game from IDLE or GAME_OVER
pause  in  1  pulse; toggles RUN<->PAUSE
btn_up/btn_down/btn_left/btn_right  in  1 each  direction requests, level
collide_in  in  1  self-collision flag from collision detection (combinational on head_x/head_y)
eat_in  in  1  fruit eaten flag from fruit generator
fruit_type_in  in  2  type of eaten fruit
head_x  out  COORD_WIDTH  current head x
head_y  out  COORD_WIDTH  current head y
dir  out  2  0=RIGHT, 1=LEFT, 2=UP, 3=DOWN
snake_length  out  LENGTH_WIDTH  current length
lives  out  3  remaining lives
step  out  1  one-cycle body-shift strobe
game_over  out  1  high in GAME_OVER
state_o  out  3  FSM state encoding

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-low.
- Reset values:
  - state IDLE, head (START_X, START_Y), dir RIGHT, pending_dir RIGHT.
  - snake_length INIT_LEN, lives INIT_LIVES.
  - step 0, game_over 0, tick counter 0, respawn counter 0.
  - Reset wins over every other input in any state.
- States: IDLE, RUN, MOVE, CHECK, RESPAWN, PAUSE, GAME_OVER.
- IDLE:
  - Holds all values.
  - start -> RUN with tick counter 0.
- RUN:
  - Counter increments each cycle.
  - At TICK_DIV-1 -> MOVE, counter cleared.
  - pause -> PAUSE with counter frozen.
  - start is ignored.
- PAUSE:
  - Holds everything; direction buttons are ignored.
  - pause -> RUN, resuming the counter value.
- Direction capture (RUN only):
  - Requests latch into pending_dir every cycle.
  - Priority when several buttons are held: up > down > left > right.
  - A request opposite to the current dir is discarded.
  - pending_dir is copied to dir on entry to MOVE.
- MOVE (1 cycle):
  - step=1.
  - Next head is computed from dir, ±1 grid unit.
  - Boundary case: if head is at x==0 moving LEFT, x==GRID_W-1 moving RIGHT, y==0 moving UP, or y==GRID_H-1 moving DOWN, set the internal boundary_hit flag and do not update the head.
  - Otherwise the head register updates at the end of MOVE.
- CHECK (1 cycle):
  - Samples collide_in and eat_in against the new head.
  - Priority: boundary_hit or collide_in > eat_in. Eating is ignored on a collision cycle.
  - Collision:
    - lives decrements.
    - If the result is 0 -> GAME_OVER with game_over=1.
    - Otherwise -> RESPAWN: head (START_X, START_Y), dir and pending_dir RIGHT, length INIT_LEN.
  - Eat:
    - Growth by fruit_type_in: 0 adds 1, 1 adds 2, 2 adds 3, 3 adds 0 length and +1 life.
    - Length saturates at MAX_LENGTH; lives saturate at MAX_LIVES.
    - -> RUN.
  - Neither: -> RUN.
  - boundary_hit clears on exit.
- RESPAWN:
  - Counts RESPAWN_CYCLES cycles, then -> RUN with tick counter 0.
  - Inputs are ignored.
- GAME_OVER:
  - Holds the final length and lives=0; game_over=1.
  - start -> RUN with head, dir, length and lives reinitialised to reset values and game_over=0.
- Move period: TICK_DIV+2 cycles (RUN, then MOVE, then CHECK).
- step rises in the cycle after the counter terminal count. collide_in and eat_in are sampled exactly 1 cycle after step.

Decomposition:
- Shared package `snake_pkg`:
  - direction encodings, FSM state encodings;
  - COORD_WIDTH, LENGTH_WIDTH, GRID_W, GRID_H;
  - fruit growth table.
- One sub-module: `move_tick_gen`, the tick divider with freeze/clear inputs and a terminal-count output.
- Head arithmetic and the FSM stay in the top module.

Test Plan:
- Reset low for 2 cycles, then start; no buttons -> step pulses every 6 cycles (TICK_DIV=4); head_x goes 11, 12, 13 with head_y=10 and dir=0.
- In RUN press btn_left (reverse) then btn_up -> left is discarded; next move gives head (13, 9) with dir=2. Pressing up and right together -> up wins.
- Walk the head to x=63 moving RIGHT -> the next MOVE leaves head_x at 63; in CHECK lives goes 3->2, state becomes RESPAWN, and after 8 cycles state is RUN with head (10, 10) and length 3.
- Assert eat_in with fruit_type_in=1 in CHECK -> length 3->5. With type 3 at lives=7 -> lives stay 7 and length is unchanged. eat_in together with collide_in -> only lives decrement.
- Drive collide_in in three consecutive CHECKs -> lives 3, 2, 1, 0, then game_over=1 and the state holds; start -> lives 3, length 3, game_over 0, state RUN.
- Assert reset mid-MOVE and pause/unpause mid-RUN -> reset restores all reset values the next cycle; the tick counter resumes its frozen value after PAUSE.
